kernel_cc_fifo_srl_status: RTL
==============================

Name: kernel_cc_fifo_srl_status

Overview:
- Parametrised shift-register FIFO for HLS dataflow channels between kernel_cc stages. Successor to the fixed-depth start/token FIFOs.
- Keeps the if_* read/write handshake and adds:
  - occupancy count;
  - almost-full / almost-empty flags with parametrised thresholds;
  - synchronous flush;
  - sticky overflow/underflow error flags.
- Sits between producer and consumer processes; the flags feed the scheduler's back-pressure logic.

Parameters:
DATA_WIDTH, 32, payload width in bits
ADDR_WIDTH, 4, SRL address width; legal only if DEPTH <= 2^ADDR_WIDTH
DEPTH, 16, entry count; legal range 2..2^ADDR_WIDTH
AFULL_THRESH, 12, if_almost_full asserted when count >= this; legal range 1..DEPTH
AEMPTY_THRESH, 2, if_almost_empty asserted when count <= this; legal range 0..DEPTH-1

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
if_din  in  DATA_WIDTH  write data
if_write  in  1  write request
if_write_ce  in  1  write clock-enable; write attempted = if_write & if_write_ce
if_full_n  out  1  1 = space available
if_dout  out  DATA_WIDTH  oldest entry, combinational read of SRL
if_read  in  1  read request
if_read_ce  in  1  read clock-enable; read attempted = if_read & if_read_ce
if_empty_n  out  1  1 = data available
if_flush  in  1  synchronous drain to empty
if_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
if_almost_full  out  1  count >= AFULL_THRESH
if_almost_empty  out  1  count <= AEMPTY_THRESH
if_overflow  out  1  sticky: write attempted while full
if_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Storage:
  - DEPTH-entry shift register. An accepted write shifts all entries up by one and loads if_din at index 0. No data reset.
  - if_dout = entry[count-1] when count > 0; entry[0] when empty (value don't-care, but no X-propagation from address).
- Accept rules:
  - wr_ok = write attempted & if_full_n.
  - rd_ok = read attempted & if_empty_n.
  - Both evaluated on the current registered flags.
- Count update per edge:
  - wr_ok & !rd_ok -> +1.
  - rd_ok & !wr_ok -> -1.
  - both or neither -> unchanged; on both, shift still occurs and the oldest entry is consumed.
- Flags:
  - if_empty_n and if_full_n are registers, updated on the same edge as count: empty_n = (next count != 0), full_n = (next count != DEPTH).
  - if_almost_full and if_almost_empty are combinational decodes of the registered count.
- Latency:
  - Write accepted at edge N into an empty FIFO -> if_empty_n = 1 and if_dout = written data from edge N onward (1-cycle write-to-read). No bypass: a read in the same cycle as the first write is not accepted.
  - Read accepted at edge N -> next-oldest entry on if_dout after edge N.
- Full boundary: write attempted while if_full_n = 0 is dropped, even if a read is accepted that cycle. Count goes DEPTH -> DEPTH-1.
- Empty boundary: read attempted while if_empty_n = 0 is ignored. A write in the same cycle is accepted normally.
- Error flags:
  - if_overflow set on any edge where write attempted & !if_full_n.
  - if_underflow set on any edge where read attempted & !if_empty_n.
  - Both hold until reset or flush.
- Flush:
  - On an edge with if_flush = 1: count = 0, if_empty_n = 0, if_full_n = 1, error flags cleared.
  - Same-cycle reads and writes are discarded and set no error flag.
  - SRL contents are not cleared.
- Reset:
  - Same effect as flush, with priority over flush, read and write.
  - Reset values: if_empty_n 0, if_full_n 1, if_count 0, if_almost_empty 1, if_almost_full 0, if_overflow 0, if_underflow 0.
  - Reset mid-operation discards all stored entries.
- Power-on: register initial values equal the reset values.

Test Plan:
1. DEPTH=4, AFULL=3, AEMPTY=1; write 0xA1, 0xA2, 0xA3, 0xA4 on 4 consecutive edges -> count 1,2,3,4; almost_full rises at count 3; full_n = 0 after 4th edge; if_dout = 0xA1.
2. From full, assert read and write (din 0xB5) together -> write dropped, overflow = 1, count 3, if_dout = 0xA2. Then read 3 times -> 0xA2, 0xA3, 0xA4 in order, empty_n = 0.
3. Empty FIFO, read and write (0xC7) same cycle -> underflow = 1, count 1, if_dout = 0xC7 on the next cycle.
4. count 2, steady read+write every cycle for 10 cycles with incrementing data -> count stays 2, outputs appear in order at 2-write lag, no flag toggles.
5. count 3 with overflow = 1, assert flush plus write -> count 0, empty_n = 0, full_n = 1, overflow = 0; the write is discarded.
6. Reset asserted during continuous writes at count 2 -> all outputs at reset values on the next edge; first write after reset deassert yields count 1 with the new data.

Source files
------------

// File: rtl/kernel_cc_fifo_srl_status.sv
// kernel_cc_fifo_srl_status
// Shift-register FIFO for HLS dataflow channels between kernel_cc stages.
// It keeps the if_* read/write handshake and adds an occupancy count,
// almost-full/almost-empty flags, a synchronous flush and sticky
// overflow/underflow error flags for the scheduler's back-pressure logic.
// Data enters at index 0 and shifts up on every accepted write.
// The oldest entry sits at index count-1 and is read combinationally.

module kernel_cc_fifo_srl_status #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic                  if_empty_n,
    input  logic                  if_flush,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_almost_full,
    output logic                  if_almost_empty,
    output logic                  if_overflow,
    output logic                  if_underflow
);

    localparam logic [ADDR_WIDTH:0] L_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] L_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] L_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    // Storage: payload only, never reset.
    logic [DATA_WIDTH-1:0] r_srl [0:DEPTH-1];

    // Control state; declaration values match the reset values so the
    // channel comes up empty even before the first reset pulse.
    logic [ADDR_WIDTH:0] r_count     = '0;
    logic                r_empty_n   = 1'b0;
    logic                r_full_n    = 1'b1;
    logic                r_overflow  = 1'b0;
    logic                r_underflow = 1'b0;

    logic                  w_wr_att;
    logic                  w_rd_att;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic [ADDR_WIDTH:0]   w_count_m1;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    // Handshake qualification. Reset and flush discard same-cycle traffic,
    // so neither can move data or occupancy on those edges.
    assign w_wr_att = if_write & if_write_ce;
    assign w_rd_att = if_read & if_read_ce;
    assign w_wr_ok  = w_wr_att & r_full_n  & ~if_flush & ~reset;
    assign w_rd_ok  = w_rd_att & r_empty_n & ~if_flush & ~reset;

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        // NOTE: default first so every path assigns w_count_nxt and no latch is inferred.
        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Shift register: accepted write shifts everything up and loads index 0.
    // On a simultaneous read the oldest entry is pushed past count-1, which
    // is exactly what consumes it.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset; only the control state below is cleared, which keeps this mappable to SRL primitives.
        if (w_wr_ok) begin
            r_srl[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_srl[i] <= r_srl[i-1];
            end
        end
    end

    // Occupancy, registered flags and sticky errors; reset beats flush beats traffic.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here samples pre-edge values.
        if (reset || if_flush) begin
            r_count     <= '0;
            r_empty_n   <= 1'b0;
            r_full_n    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_empty_n <= (w_count_nxt != '0);
            r_full_n  <= (w_count_nxt != L_DEPTH);
            if (w_wr_att && !r_full_n) begin
                r_overflow <= 1'b1;
            end
            if (w_rd_att && !r_empty_n) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Read address: count-1 when occupied, index 0 when empty so the mux
    // select is always a defined value.
    assign w_count_m1 = r_count - 1'b1;
    assign w_rd_addr  = (r_count != '0) ? w_count_m1[ADDR_WIDTH-1:0] : '0;

    assign if_dout         = r_srl[w_rd_addr];
    assign if_count        = r_count;
    assign if_empty_n      = r_empty_n;
    assign if_full_n       = r_full_n;
    assign if_almost_full  = (r_count >= L_AFULL);
    assign if_almost_empty = (r_count <= L_AEMPTY);
    assign if_overflow     = r_overflow;
    assign if_underflow    = r_underflow;

endmodule
